// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle right shifter: FSM state encodings,
// R-type funct codes for the right-shift operations, and default sizes.
package shift_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_SHAMT_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
   localparam logic [5:0] FUNCT_SRA  = 6'b000011;
   localparam logic [5:0] FUNCT_SRLV = 6'b000110;
   localparam logic [5:0] FUNCT_SRAV = 6'b000111;

endpackage

// File: rtl/mux2to1.sv
// Single-bit 2:1 multiplexer cell; y = s ? b : a.
module mux2to1 (
   input  logic a,
   input  logic b,
   input  logic s,
   output logic y
);

   assign y = s ? b : a;

endmodule

// File: rtl/right_mux_level.sv
// One log-shifter level with a selectable level index: M = s ? (A >> 2**lvl, fill) : A.
// The per-bit pass/shift decision is made by mux2to1 cells.
module right_mux_level #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int LVL_W   = 3
) (
   output logic [WIDTH-1:0] M,
   input  logic [WIDTH-1:0] A,
   input  logic             fill,
   input  logic [LVL_W-1:0] lvl,
   input  logic             s
);

   logic [WIDTH-1:0] shifted [SHAMT_W];
   logic [WIDTH-1:0] sel;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
      assign shifted[k] = {{(2**k){fill}}, A[WIDTH-1:2**k]};
   end

   always_comb begin
      sel = A;
      for (int k = 0; k < SHAMT_W; k++) begin
         if (lvl == LVL_W'(k)) sel = shifted[k];
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      mux2to1 u_mux (
         .a(A[i]),
         .b(sel[i]),
         .s(s),
         .y(M[i])
      );
   end

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle SRL/SRA unit: one log-shifter level per clock (1,2,4,8,16),
// valid/ready handshake on operand and result sides.
module seq_right_shifter
   import shift_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SHAMT_W = DEF_SHAMT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic               in_arith,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               busy
);

   localparam int LVL_W = $clog2(SHAMT_W);

   state_e             state_q, state_d;
   logic [LVL_W-1:0]   lvl_q, lvl_d;
   logic [SHAMT_W-1:0] shamt_q, shamt_d;
   logic               fill_q, fill_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [WIDTH-1:0]   level_out;

   right_mux_level #(
      .WIDTH(WIDTH),
      .SHAMT_W(SHAMT_W),
      .LVL_W(LVL_W)
   ) u_level (
      .M(level_out),
      .A(data_q),
      .fill(fill_q),
      .lvl(lvl_q),
      .s(shamt_q[lvl_q])
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lvl_q   <= '0;
         shamt_q <= '0;
         fill_q  <= 1'b0;
         data_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
         shamt_q <= shamt_d;
         fill_q  <= fill_d;
         data_q  <= data_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      shamt_d = shamt_q;
      fill_d  = fill_q;
      data_d  = data_q;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               shamt_d = in_shamt;
               // fill is frozen at acceptance so every level sees the same sign
               fill_d  = in_arith & in_data[WIDTH-1];
               lvl_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            data_d = level_out;
            lvl_d  = lvl_q + LVL_W'(1);
            if (lvl_q == LVL_W'(SHAMT_W - 1)) begin
               out_d   = level_out;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = out_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Self-checking bench for seq_right_shifter: directed vector table, handshake
// corner sequences, and a randomized sweep against a >> / >>> reference.
module tb_seq_right_shifter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic        in_arith;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   seq_right_shifter dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_shamt(in_shamt),
      .in_arith(in_arith),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  shamt;
      logic        arith;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] sh,
                                         input logic ar);
      if (ar) return 32'($signed(d) >>> sh);
      return d >> sh;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Runs one operation; stall = cycles out_ready is held low in DONE,
   // pulse = drive spurious in_valid requests while stalled and on the release edge.
   task automatic run_op(input string nm, input logic [31:0] d, input logic [4:0] sh,
                         input logic ar, input logic [31:0] exp, input int stall,
                         input bit pulse);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      chk({nm, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = sh;
      in_arith = ar;
      tick();
      in_valid = 1'b0;
      in_data  = $urandom;
      in_shamt = 5'($urandom);
      in_arith = 1'($urandom);
      chk({nm, "_busy_e0"}, {31'b0, busy}, 32'd1);
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk({nm, "_latency"}, n, 32'd5);
      chk({nm, "_data"}, out_data, exp);
      for (int i = 0; i < stall; i++) begin
         if (pulse) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_shamt = 5'($urandom);
         end
         tick();
         in_valid = 1'b0;
         chk({nm, "_stall_valid"}, {31'b0, out_valid}, 32'd1);
         chk({nm, "_stall_data"}, out_data, exp);
      end
      out_ready = 1'b1;
      if (pulse) in_valid = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({nm, "_release_ready"}, {31'b0, in_ready}, 32'd1);
      chk({nm, "_release_busy"}, {31'b0, busy}, 32'd0);
      chk({nm, "_release_valid"}, {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      logic [4:0]  sh;
      logic        ar;
      int          stall;
      int          stale;

      vecs[0] = '{32'h12345678, 5'd4,  1'b0, 32'h01234567};
      vecs[1] = '{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF};
      vecs[2] = '{32'h80000000, 5'd31, 1'b0, 32'h00000001};
      vecs[3] = '{32'hDEADBEEF, 5'd0,  1'b0, 32'hDEADBEEF};
      vecs[4] = '{32'hDEADBEEF, 5'd0,  1'b1, 32'hDEADBEEF};
      vecs[5] = '{32'hF0000000, 5'd4,  1'b1, 32'hFF000000};
      vecs[6] = '{32'h7FFFFFFF, 5'd16, 1'b1, 32'h00007FFF};
      vecs[7] = '{32'hAAAAAAAA, 5'd1,  1'b0, 32'h55555555};
      vecs[8] = '{32'hAAAAAAAA, 5'd1,  1'b1, 32'hD5555555};
      vecs[9] = '{32'hC0000001, 5'd31, 1'b0, 32'h00000001};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_arith  = 1'b0;
      out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

      for (int i = 0; i < 10; i++)
         run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].shamt, vecs[i].arith,
                vecs[i].exp, 0, 1'b0);

      run_op("backpressure", 32'h89ABCDEF, 5'd8, 1'b1, 32'hFF89ABCD, 10, 1'b1);

      // Reset asserted so that it lands on edge E3 of an operation
      in_valid = 1'b1;
      in_data  = 32'hFFFF0000;
      in_shamt = 5'd3;
      in_arith = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_out_data", out_data, 32'd0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      rst_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid || busy) stale++;
      end
      chk("midrst_no_stale", stale, 32'd0);

      for (int i = 0; i < 1000; i++) begin
         d     = $urandom;
         sh    = 5'($urandom);
         ar    = 1'($urandom);
         stall = (($urandom & 7) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_op("rand", d, sh, ar, model(d, sh, ar), stall, 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
